// File: rtl/argon_regfile_mp.sv
// Multi-port register file with a pending-write scoreboard.
// Each read port has 1-cycle registered data; the single write port bypasses to same-cycle reads.
module argon_regfile_mp #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int IDXW    = $clog2(NUM_REGS)
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_wr_valid,
    input  logic [IDXW-1:0]          i_wr_idx,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_claim,
    input  logic [IDXW-1:0]          i_claim_idx,
    input  logic [NUM_RD-1:0]        i_rd_valid,
    input  logic [NUM_RD*IDXW-1:0]   i_rd_idx,
    output logic [NUM_RD-1:0]        o_rd_ready,
    output logic [NUM_RD-1:0]        o_rd_valid,
    output logic [NUM_RD*WIDTH-1:0]  o_rd_data,
    output logic [NUM_REGS-1:0]      o_busy
);

    localparam logic [IDXW:0] NumRegsW = (IDXW+1)'(NUM_REGS);

    // Only in-range, non-hardwired registers hold state; everything else reads as 0, always ready.
    function automatic logic isWritable(input logic [IDXW-1:0] idx);
        isWritable = ({1'b0, idx} < NumRegsW) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    logic [WIDTH-1:0]        regFile [NUM_REGS];
    logic [NUM_REGS-1:0]     busyReg;
    logic [NUM_RD-1:0]       rdValidReg;
    logic [NUM_RD*WIDTH-1:0] rdDataReg;

    logic                    wrEn;
    logic                    claimEn;
    logic [NUM_RD-1:0]       rdAccept;
    logic [WIDTH-1:0]        rdValue [NUM_RD];

    assign wrEn    = i_wr_valid && isWritable(i_wr_idx);
    assign claimEn = i_claim && isWritable(i_claim_idx);

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [IDXW-1:0] rdIdx;
            logic            portWritable;
            logic            wrHit;

            assign rdIdx        = i_rd_idx[gi*IDXW +: IDXW];
            assign portWritable = isWritable(rdIdx);
            assign wrHit        = wrEn && (i_wr_idx == rdIdx);

            assign o_rd_ready[gi] = !portWritable || !busyReg[rdIdx] || wrHit;
            assign rdAccept[gi]   = i_rd_valid[gi] && o_rd_ready[gi];
            assign rdValue[gi]    = !portWritable ? '0 :
                                    wrHit        ? i_wr_data : regFile[rdIdx];
        end
    endgenerate

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regFile[r] <= '0;
            end
            busyReg    <= '0;
            rdValidReg <= '0;
            rdDataReg  <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wrEn && (i_wr_idx == IDXW'(r))) begin
                    regFile[r] <= i_wr_data;
                end
                // A claim in the same cycle as the write-back marks a new producer, so it wins.
                if (claimEn && (i_claim_idx == IDXW'(r))) begin
                    busyReg[r] <= 1'b1;
                end else if (wrEn && (i_wr_idx == IDXW'(r))) begin
                    busyReg[r] <= 1'b0;
                end
            end
            for (int p = 0; p < NUM_RD; p++) begin
                rdValidReg[p] <= rdAccept[p];
                if (rdAccept[p]) begin
                    rdDataReg[p*WIDTH +: WIDTH] <= rdValue[p];
                end
            end
        end
    end

    assign o_rd_valid = rdValidReg;
    assign o_rd_data  = rdDataReg;
    assign o_busy     = busyReg;

endmodule

// File: tb/tb_argon_regfile_mp.sv
// Directed testbench for argon_regfile_mp with a behavioural register-file model
// checked every cycle, plus literal expectations for each scenario.
module tb_argon_regfile_mp;

    localparam int WIDTH    = 16;
    localparam int NUM_REGS = 16;
    localparam int NUM_RD   = 2;
    localparam int IDXW     = 4;

    logic                    clk = 1'b0;
    logic                    rstN = 1'b0;
    logic                    wrValid = 1'b0;
    logic [IDXW-1:0]         wrIdx = '0;
    logic [WIDTH-1:0]        wrData = '0;
    logic                    claim = 1'b0;
    logic [IDXW-1:0]         claimIdx = '0;
    logic [NUM_RD-1:0]       rdValid = '0;
    logic [NUM_RD*IDXW-1:0]  rdIdx = '0;
    logic [NUM_RD-1:0]       rdReady;
    logic [NUM_RD-1:0]       rdValidOut;
    logic [NUM_RD*WIDTH-1:0] rdData;
    logic [NUM_REGS-1:0]     busy;

    int errors = 0;
    int checks = 0;

    argon_regfile_mp #(
        .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .ZERO_REG(1)
    ) dut (
        .i_Clk(clk),
        .i_Reset_n(rstN),
        .i_wr_valid(wrValid),
        .i_wr_idx(wrIdx),
        .i_wr_data(wrData),
        .i_claim(claim),
        .i_claim_idx(claimIdx),
        .i_rd_valid(rdValid),
        .i_rd_idx(rdIdx),
        .o_rd_ready(rdReady),
        .o_rd_valid(rdValidOut),
        .o_rd_data(rdData),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural registers, pending bits and per-port expected result.
    logic [WIDTH-1:0] mRegs [NUM_REGS];
    logic             mBusy [NUM_REGS];
    logic             mValid [NUM_RD];
    logic [WIDTH-1:0] mData [NUM_RD];

    function automatic logic modelReady(input int idx);
        if (idx == 0) return 1'b1;
        return !mBusy[idx] || (wrValid && int'(wrIdx) == idx);
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mRegs[r] = '0;
                mBusy[r] = 1'b0;
            end
            for (int p = 0; p < NUM_RD; p++) begin
                mValid[p] = 1'b0;
                mData[p]  = '0;
            end
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                int idx;
                idx = int'(rdIdx[p*IDXW +: IDXW]);
                if (rdValid[p] && modelReady(idx)) begin
                    mValid[p] = 1'b1;
                    if (idx == 0) mData[p] = '0;
                    else if (wrValid && int'(wrIdx) == idx) mData[p] = wrData;
                    else mData[p] = mRegs[idx];
                end else begin
                    mValid[p] = 1'b0;
                end
            end
            if (wrValid && wrIdx != 0) begin
                mRegs[wrIdx] = wrData;
                mBusy[wrIdx] = 1'b0;
            end
            if (claim && claimIdx != 0) mBusy[claimIdx] = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (rstN) begin
            logic [NUM_REGS-1:0] expBusy;
            for (int r = 0; r < NUM_REGS; r++) expBusy[r] = mBusy[r];
            check("model_busy", 32'(busy), 32'(expBusy));
            for (int p = 0; p < NUM_RD; p++) begin
                check("model_ready", 32'(rdReady[p]), 32'(modelReady(int'(rdIdx[p*IDXW +: IDXW]))));
                check("model_valid", 32'(rdValidOut[p]), 32'(mValid[p]));
                check("model_data", 32'(rdData[p*WIDTH +: WIDTH]), 32'(mData[p]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wrValid = 1'b0;
        claim   = 1'b0;
        rdValid = '0;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_valid", 32'(rdValidOut), 32'h0);
        check("rst_data", rdData, 32'h0);
        rstN = 1'b1;
        tick();

        // 1: all registers read 0 after reset
        for (int i = 1; i < NUM_REGS; i++) begin
            rdValid = 2'b11;
            rdIdx   = {4'(i), 4'(i)};
            tick();
            check("t1_valid", 32'(rdValidOut), 32'h3);
            check("t1_data", rdData, 32'h0);
        end
        check("t1_busy", 32'(busy), 32'h0);

        // 2: write then read, r0 on the other port
        idle();
        wrValid = 1'b1; wrIdx = 4'd3; wrData = 16'hBEEF;
        tick();
        idle();
        rdValid = 2'b11; rdIdx = {4'd0, 4'd3};
        tick();
        check("t2_valid", 32'(rdValidOut), 32'h3);
        check("t2_data", rdData, 32'h0000BEEF);

        // 3: same-cycle write bypass
        idle();
        wrValid = 1'b1; wrIdx = 4'd5; wrData = 16'h1234;
        rdValid = 2'b01; rdIdx = {4'd3, 4'd5};
        tick();
        check("t3_bypass", 32'(rdData[15:0]), 32'h1234);
        idle();
        tick();
        check("t3_hold", 32'(rdData[15:0]), 32'h1234);

        // 4: claim stalls a read until write-back
        claim = 1'b1; claimIdx = 4'd7;
        tick();
        idle();
        rdValid = 2'b01; rdIdx = {4'd0, 4'd7};
        #1;
        check("t4_ready_lo", 32'(rdReady[0]), 32'h0);
        tick();
        check("t4_stall", 32'(rdValidOut[0]), 32'h0);
        check("t4_busy", 32'(busy[7]), 32'h1);
        wrValid = 1'b1; wrIdx = 4'd7; wrData = 16'h00A5;
        #1;
        check("t4_ready_hi", 32'(rdReady[0]), 32'h1);
        tick();
        check("t4_valid", 32'(rdValidOut[0]), 32'h1);
        check("t4_data", 32'(rdData[15:0]), 32'h00A5);
        check("t4_busy_clr", 32'(busy[7]), 32'h0);

        // 5: claim and write same cycle, claim wins
        idle();
        claim = 1'b1; claimIdx = 4'd9;
        wrValid = 1'b1; wrIdx = 4'd9; wrData = 16'h5555;
        tick();
        check("t5_busy", 32'(busy[9]), 32'h1);
        idle();
        rdValid = 2'b10; rdIdx = {4'd9, 4'd0};
        tick();
        check("t5_stall1", 32'(rdValidOut[1]), 32'h0);
        tick();
        check("t5_stall2", 32'(rdValidOut[1]), 32'h0);
        wrValid = 1'b1; wrIdx = 4'd9; wrData = 16'h6666;
        tick();
        check("t5_valid", 32'(rdValidOut[1]), 32'h1);
        check("t5_data", 32'(rdData[31:16]), 32'h6666);

        // 6: r0 ignores writes and claims; reset mid-read
        idle();
        wrValid = 1'b1; wrIdx = 4'd0; wrData = 16'hFFFF;
        claim = 1'b1; claimIdx = 4'd0;
        tick();
        check("t6_busy0", 32'(busy[0]), 32'h0);
        idle();
        rdValid = 2'b11; rdIdx = {4'd9, 4'd0};
        #1;
        check("t6_ready0", 32'(rdReady[0]), 32'h1);
        tick();
        check("t6_valid", 32'(rdValidOut), 32'h3);
        check("t6_data", rdData, 32'h66660000);
        tick();
        #1;
        rstN = 1'b0;
        #1;
        check("t6_rst_valid", 32'(rdValidOut), 32'h0);
        check("t6_rst_data", rdData, 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        idle();
        tick();
        rstN = 1'b1;
        rdValid = 2'b01; rdIdx = {4'd0, 4'd3};
        tick();
        check("t6_post_rst", 32'(rdData[15:0]), 32'h0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
